// File: rtl/sw_job_arbiter.sv
// sw_job_arbiter: round-robin arbiter sharing one alignment core between two requesters,
// one job in flight, with length validation and a watchdog on the core result.
module sw_job_arbiter #(
    parameter int REF_MAX_LENGTH  = 128,
    parameter int READ_MAX_LENGTH = 128,
    parameter int SCORE_W         = 10,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                                 avm_clk,
    input  logic                                 avm_rst,
    input  logic [1:0]                           req_valid,
    output logic [1:0]                           req_ready,
    input  logic [1:0][2*REF_MAX_LENGTH-1:0]     req_ref,
    input  logic [1:0][2*READ_MAX_LENGTH-1:0]    req_read,
    input  logic [1:0][7:0]                      req_ref_len,
    input  logic [1:0][7:0]                      req_read_len,
    output logic [1:0]                           rsp_valid,
    input  logic [1:0]                           rsp_ready,
    output logic [SCORE_W-1:0]                   rsp_score,
    output logic [6:0]                           rsp_column,
    output logic [6:0]                           rsp_row,
    output logic [1:0]                           rsp_status,
    output logic                                 core_i_valid,
    input  logic                                 core_o_ready,
    output logic [2*REF_MAX_LENGTH-1:0]          core_seq_ref,
    output logic [2*READ_MAX_LENGTH-1:0]         core_seq_read,
    output logic [7:0]                           core_ref_len,
    output logic [7:0]                           core_read_len,
    output logic                                 core_i_ready,
    input  logic                                 core_o_valid,
    input  logic [SCORE_W-1:0]                   core_score,
    input  logic [6:0]                           core_column,
    input  logic [6:0]                           core_row,
    output logic                                 busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [8:0] REF_MAX  = 9'(REF_MAX_LENGTH);
    localparam logic [8:0] READ_MAX = 9'(READ_MAX_LENGTH);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        grant;
    logic        last_grant;
    logic        nxt_g;
    logic        len_err;
    logic [31:0] wd;

    // Lone requester wins; on a tie the one not served last time wins.
    always_comb nxt_g = req_valid[1] & (~req_valid[0] | ~last_grant);
    always_comb len_err = core_ref_len == 8'd0 || core_read_len == 8'd0 ||
                          {1'b0, core_ref_len} > REF_MAX || {1'b0, core_read_len} > READ_MAX;
    always_comb busy = state != IDLE;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            wd            <= '0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_score     <= '0;
            rsp_column    <= '0;
            rsp_row       <= '0;
            rsp_status    <= '0;
            core_i_valid  <= 1'b0;
            core_i_ready  <= 1'b0;
            core_seq_ref  <= '0;
            core_seq_read <= '0;
            core_ref_len  <= '0;
            core_read_len <= '0;
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: if (|req_valid) begin
                    grant         <= nxt_g;
                    req_ready     <= 2'b01 << nxt_g;
                    core_seq_ref  <= req_ref[nxt_g];
                    core_seq_read <= req_read[nxt_g];
                    core_ref_len  <= req_ref_len[nxt_g];
                    core_read_len <= req_read_len[nxt_g];
                    state         <= ISSUE;
                end
                // First ISSUE cycle validates the latched lengths before offering the job.
                ISSUE: if (!core_i_valid) begin
                    if (len_err) begin
                        rsp_status <= 2'b01;
                        rsp_score  <= '0;
                        rsp_column <= '0;
                        rsp_row    <= '0;
                        rsp_valid  <= 2'b01 << grant;
                        state      <= RESP;
                    end else
                        core_i_valid <= 1'b1;
                end else if (core_o_ready) begin
                    core_i_valid <= 1'b0;
                    core_i_ready <= 1'b1;
                    wd           <= '0;
                    state        <= WAIT;
                end
                WAIT: if (core_o_valid) begin
                    rsp_status   <= 2'b00;
                    rsp_score    <= core_score;
                    rsp_column   <= core_column;
                    rsp_row      <= core_row;
                    rsp_valid    <= 2'b01 << grant;
                    core_i_ready <= 1'b0;
                    state        <= RESP;
                end else if (wd == WD_LAST) begin
                    rsp_status   <= 2'b10;
                    rsp_score    <= '0;
                    rsp_column   <= '0;
                    rsp_row      <= '0;
                    rsp_valid    <= 2'b01 << grant;
                    core_i_ready <= 1'b0;
                    state        <= RESP;
                end else
                    wd <= wd + 32'd1;
                RESP: if (rsp_ready[grant]) begin
                    rsp_valid  <= '0;
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sw_job_arbiter.sv
// tb_sw_job_arbiter: directed checks of sw_job_arbiter; a second instance with a
// 16-cycle watchdog shares all inputs and is only checked in the timeout scenarios.
module tb_sw_job_arbiter;
    logic                   avm_clk = 1'b0;
    logic                   avm_rst = 1'b1;
    logic [1:0]             req_valid = '0;
    logic [1:0][255:0]      req_ref = '0;
    logic [1:0][255:0]      req_read = '0;
    logic [1:0][7:0]        req_ref_len = '0;
    logic [1:0][7:0]        req_read_len = '0;
    logic [1:0]             rsp_ready = '0;
    logic                   core_o_ready = 1'b0;
    logic                   core_o_valid = 1'b0;
    logic [9:0]             core_score = '0;
    logic [6:0]             core_column = '0;
    logic [6:0]             core_row = '0;

    logic [1:0]   req_ready, rsp_valid, rsp_status, req_ready_t, rsp_valid_t, rsp_status_t;
    logic [9:0]   rsp_score, rsp_score_t;
    logic [6:0]   rsp_column, rsp_row, rsp_column_t, rsp_row_t;
    logic         core_i_valid, core_i_ready, busy, core_i_valid_t, core_i_ready_t, busy_t;
    logic [255:0] core_seq_ref, core_seq_read, core_seq_ref_t, core_seq_read_t;
    logic [7:0]   core_ref_len, core_read_len, core_ref_len_t, core_read_len_t;

    int n_chk = 0;
    int n_fail = 0;
    int exp_g[3] = '{0, 1, 0};

    always #5 avm_clk = ~avm_clk;

    sw_job_arbiter dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_ref(req_ref), .req_read(req_read), .req_ref_len(req_ref_len), .req_read_len(req_read_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_score(rsp_score), .rsp_column(rsp_column),
        .rsp_row(rsp_row), .rsp_status(rsp_status), .core_i_valid(core_i_valid), .core_o_ready(core_o_ready),
        .core_seq_ref(core_seq_ref), .core_seq_read(core_seq_read), .core_ref_len(core_ref_len),
        .core_read_len(core_read_len), .core_i_ready(core_i_ready), .core_o_valid(core_o_valid),
        .core_score(core_score), .core_column(core_column), .core_row(core_row), .busy(busy)
    );

    sw_job_arbiter #(.TIMEOUT_CYCLES(16)) dut_t (
        .avm_clk(avm_clk), .avm_rst(avm_rst), .req_valid(req_valid), .req_ready(req_ready_t),
        .req_ref(req_ref), .req_read(req_read), .req_ref_len(req_ref_len), .req_read_len(req_read_len),
        .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready), .rsp_score(rsp_score_t), .rsp_column(rsp_column_t),
        .rsp_row(rsp_row_t), .rsp_status(rsp_status_t), .core_i_valid(core_i_valid_t), .core_o_ready(core_o_ready),
        .core_seq_ref(core_seq_ref_t), .core_seq_read(core_seq_read_t), .core_ref_len(core_ref_len_t),
        .core_read_len(core_read_len_t), .core_i_ready(core_i_ready_t), .core_o_valid(core_o_valid),
        .core_score(core_score), .core_column(core_column), .core_row(core_row), .busy(busy_t)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge avm_clk);
    endtask

    task automatic do_reset();
        avm_rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        core_o_ready = 1'b0;
        core_o_valid = 1'b0;
        tick(2);
        avm_rst = 1'b0;
        tick();
    endtask

    initial begin
        req_ref[0] = {8{32'hA5A5_0F0F}};
        req_ref[1] = {8{32'h1234_5678}};
        req_read[0] = {8{32'hDEAD_BEEF}};
        req_read[1] = {8{32'h0BAD_F00D}};
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_core_i_valid", core_i_valid, 0);
        chk("rst_core_i_ready", core_i_ready, 0);
        chk("rst_core_ref_len", core_ref_len, 0);
        chk("rst_core_seq_ref", core_seq_ref, 0);

        // Single requester, full-length job, core answers 300 cycles into WAIT.
        req_ref_len = {8'd128, 8'd128};
        req_read_len = {8'd128, 8'd128};
        req_valid = 2'b01;
        tick();
        chk("j1_req_ready", req_ready, 2'b01);
        chk("j1_busy", busy, 1);
        chk("j1_core_ref_len", core_ref_len, 128);
        chk("j1_core_read_len", core_read_len, 128);
        chk("j1_seq_ref", core_seq_ref, {8{32'hA5A5_0F0F}});
        chk("j1_seq_read", core_seq_read, {8{32'hDEAD_BEEF}});
        chk("j1_no_ivalid_yet", core_i_valid, 0);
        req_valid = 2'b00;
        tick();
        chk("j1_req_ready_pulse", req_ready, 0);
        chk("j1_ivalid", core_i_valid, 1);
        tick(2);
        chk("j1_ivalid_held", core_i_valid, 1);
        chk("j1_seq_stable", core_seq_ref, {8{32'hA5A5_0F0F}});
        core_o_ready = 1'b1;
        tick();
        core_o_ready = 1'b0;
        chk("j1_wait_ivalid", core_i_valid, 0);
        chk("j1_wait_iready", core_i_ready, 1);
        tick(299);
        chk("j1_no_rsp_yet", rsp_valid, 0);
        core_o_valid = 1'b1;
        core_score = 10'd100;
        core_column = 7'd127;
        core_row = 7'd127;
        tick();
        core_o_valid = 1'b0;
        core_score = '0;
        chk("j1_rsp_valid", rsp_valid, 2'b01);
        chk("j1_status", rsp_status, 2'b00);
        chk("j1_score", rsp_score, 100);
        chk("j1_column", rsp_column, 127);
        chk("j1_row", rsp_row, 127);
        chk("j1_iready_drop", core_i_ready, 0);
        req_valid = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_rsp_valid", rsp_valid, 2'b01);
            chk("hold_score", rsp_score, 100);
            chk("hold_no_grant", req_ready, 0);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("j1_idle_busy", busy, 0);
        chk("j1_rsp_cleared", rsp_valid, 0);
        tick();
        chk("pending_granted", req_ready, 2'b10);
        chk("pending_len", core_ref_len, 128);

        // Both requesting continuously: grants alternate 0,1,0.
        do_reset();
        req_ref_len = {8'd5, 8'd4};
        req_read_len = {8'd6, 8'd6};
        core_o_ready = 1'b1;
        core_o_valid = 1'b1;
        core_score = 10'd9;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 20 && req_ready == 2'b00; i++) tick();
            chk("rr_grant", req_ready, 2'b01 << exp_g[j]);
            chk("rr_len", core_ref_len, exp_g[j] ? 5 : 4);
            for (int i = 0; i < 20 && rsp_valid == 2'b00; i++) tick();
            chk("rr_rsp", rsp_valid, 2'b01 << exp_g[j]);
            chk("rr_score", rsp_score, 9);
        end

        // Zero read length is rejected without touching the core.
        do_reset();
        req_ref_len = {8'd10, 8'd10};
        req_read_len = {8'd10, 8'd0};
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        chk("le_grant", req_ready, 2'b01);
        chk("le_ivalid0", core_i_valid, 0);
        tick();
        chk("le_ivalid1", core_i_valid, 0);
        chk("le_rsp_valid", rsp_valid, 2'b01);
        chk("le_status", rsp_status, 2'b01);
        chk("le_score", rsp_score, 0);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("le_idle", busy, 0);
        // Over-long reference is rejected too.
        req_ref_len = {8'd10, 8'd200};
        req_read_len = {8'd10, 8'd10};
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        chk("le_long_status", rsp_status, 2'b01);
        chk("le_long_ivalid", core_i_valid, 0);

        // Watchdog on the 16-cycle instance: silent core, then a last-cycle answer.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            req_ref_len = {8'd8, 8'd8};
            req_read_len = {8'd8, 8'd8};
            core_score = 10'd55;
            core_column = 7'd3;
            core_row = 7'd4;
            core_o_ready = 1'b1;
            req_valid = 2'b01;
            tick();
            req_valid = 2'b00;
            tick();
            chk("to_ivalid", core_i_valid_t, 1);
            tick();
            core_o_ready = 1'b0;
            chk("to_wait_entry", core_i_ready_t, 1);
            tick(15);
            chk("to_not_early", rsp_valid_t, 0);
            if (k == 1) begin
                core_o_valid = 1'b1;
                core_score = 10'd77;
            end
            tick();
            core_o_valid = 1'b0;
            chk("to_rsp_valid", rsp_valid_t, 2'b01);
            chk("to_status", rsp_status_t, k ? 2'b00 : 2'b10);
            chk("to_score", rsp_score_t, k ? 77 : 0);
            chk("to_row", rsp_row_t, k ? 4 : 0);
        end

        // Reset while waiting on the core abandons the job.
        do_reset();
        core_o_ready = 1'b1;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick(2);
        chk("rw_busy", busy, 1);
        chk("rw_iready", core_i_ready, 1);
        avm_rst = 1'b1;
        req_valid = 2'b01;
        tick();
        chk("rw_busy_rst", busy, 0);
        chk("rw_req_ready_rst", req_ready, 0);
        chk("rw_iready_rst", core_i_ready, 0);
        chk("rw_rsp_rst", rsp_valid, 0);
        avm_rst = 1'b0;
        req_valid = 2'b00;
        tick();
        chk("rw_no_rsp", rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
